// File: rtl/mem_access_seq_if.sv
// Controller- and memory-side bus of the memory access sequencer.
// The sequencer takes the slave view; whatever drives requests and models memory takes master.
interface mem_access_seq_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
);
    logic              req_valid;
    logic              req_write;
    logic              req_ready;
    logic [ADDR_W-1:0] addr_bus;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rd;
    logic              mem_wr;
    logic              mem_wait;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] rd_data;
    logic              done;
    logic              busy;
    logic              led_rd;
    logic              led_wr;

    modport slave (
        input  req_valid, req_write, addr_bus, wr_data, mem_wait, mem_rdata,
        output req_ready, mem_addr, mem_wdata, mem_rd, mem_wr, rd_data, done, busy,
               led_rd, led_wr
    );

    modport master (
        output req_valid, req_write, addr_bus, wr_data, mem_wait, mem_rdata,
        input  req_ready, mem_addr, mem_wdata, mem_rd, mem_wr, rd_data, done, busy,
               led_rd, led_wr
    );
endinterface

// File: rtl/mem_access_seq.sv
// Paced memory cycle sequencer: latches the M1:M2 address, then runs setup, strobe and hold
// phases sized to relay settle times, returning read data with a one-cycle done pulse.
module mem_access_seq #(
    parameter int unsigned ADDR_W        = 16,
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned SETTLE_CYCLES = 3,
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES   = 1
) (
    input logic              clk,
    input logic              rst_n,
    mem_access_seq_if.slave  bus
);
    localparam bit ParamsOk = (SETTLE_CYCLES >= 1) && (SETTLE_CYCLES <= 15) &&
                              (STROBE_CYCLES >= 1) && (STROBE_CYCLES <= 15) &&
                              (HOLD_CYCLES >= 1) && (HOLD_CYCLES <= 15);

    localparam logic [3:0] SetupLoad  = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] StrobeLoad = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] HoldLoad   = 4'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StDone} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              wr_q, wr_d;
    logic              strobe_rd, strobe_wr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            wr_q    <= wr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        wr_d    = wr_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    state_d = StSetup;
                    cnt_d   = SetupLoad;
                    addr_d  = bus.addr_bus;
                    wdata_d = bus.wr_data;
                    wr_d    = bus.req_write;
                end
            end
            StSetup: begin
                if (cnt_q == '0) begin
                    state_d = StStrobe;
                    cnt_d   = StrobeLoad;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StStrobe: begin
                // mem_wait only matters once the minimum strobe length has elapsed
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (!bus.mem_wait) begin
                    state_d = StHold;
                    cnt_d   = HoldLoad;
                    if (!wr_q) begin
                        rdata_d = bus.mem_rdata;
                    end
                end
            end
            StHold: begin
                if (cnt_q == '0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign strobe_rd = (state_q == StStrobe) && !wr_q;
    assign strobe_wr = (state_q == StStrobe) && wr_q;

    assign bus.req_ready = (state_q == StIdle);
    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = (state_q == StDone);
    assign bus.mem_rd    = strobe_rd;
    assign bus.mem_wr    = strobe_wr;
    assign bus.led_rd    = strobe_rd;
    assign bus.led_wr    = strobe_wr;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.rd_data   = rdata_q;

    always_ff @(posedge clk) begin
        cfg_check: assert (ParamsOk)
            else $error("mem_access_seq: phase cycle parameters must lie in 1..15");
    end
endmodule

// File: tb/tb_mem_access_seq.sv
// Drives two sequencers (default phases and S=T=H=1) with identical stimulus and compares
// each cycle against a window-arithmetic model of the memory cycle.
module tb_mem_access_seq;
    localparam int NC = 40;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_write, mem_wait;
    logic [15:0] addr_bus;
    logic [7:0]  wr_data, mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_seq_if #(.ADDR_W(16), .DATA_W(8)) bus_a ();
    mem_access_seq_if #(.ADDR_W(16), .DATA_W(8)) bus_b ();

    assign bus_a.req_valid = req_valid;
    assign bus_a.req_write = req_write;
    assign bus_a.addr_bus  = addr_bus;
    assign bus_a.wr_data   = wr_data;
    assign bus_a.mem_wait  = mem_wait;
    assign bus_a.mem_rdata = mem_rdata;
    assign bus_b.req_valid = req_valid;
    assign bus_b.req_write = req_write;
    assign bus_b.addr_bus  = addr_bus;
    assign bus_b.wr_data   = wr_data;
    assign bus_b.mem_wait  = mem_wait;
    assign bus_b.mem_rdata = mem_rdata;

    mem_access_seq #(
        .ADDR_W(16), .DATA_W(8), .SETTLE_CYCLES(3), .STROBE_CYCLES(2), .HOLD_CYCLES(1)
    ) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    mem_access_seq #(
        .ADDR_W(16), .DATA_W(8), .SETTLE_CYCLES(1), .STROBE_CYCLES(1), .HOLD_CYCLES(1)
    ) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    int s_of [2] = '{3, 1};
    int t_of [2] = '{2, 1};
    int h_of [2] = '{1, 1};

    // Per-cycle stimulus
    logic        valid_pat [NC];
    logic        wait_pat  [NC];
    logic        rstn_pat  [NC];
    logic [15:0] addr_pat  [NC];
    logic [7:0]  rdata_pat [NC];

    // Flags are {mem_rd, mem_wr, done, busy, req_ready, led_rd, led_wr}
    logic [6:0]  obs_flags [2][NC];
    logic [15:0] obs_addr  [2][NC];
    logic [7:0]  obs_wdata [2][NC];
    logic [7:0]  obs_rdd   [2][NC];
    logic [6:0]  exp_flags [2][NC];
    logic [15:0] exp_addr  [2][NC];
    logic [7:0]  exp_wdata [2][NC];
    logic [7:0]  exp_rdd   [2][NC];
    int          exp_dn    [2];
    int          exp_se    [2];

    logic [15:0] model_addr  [2];
    logic [7:0]  model_wdata [2];
    logic [7:0]  model_rdd   [2];

    task automatic stim_default(input logic [15:0] addr);
        for (int c = 0; c < NC; c++) begin
            valid_pat[c] = (c == 0);
            wait_pat[c]  = 1'b0;
            rstn_pat[c]  = 1'b1;
            addr_pat[c]  = addr;
            rdata_pat[c] = 8'($urandom);
        end
    endtask

    // Reference: one accept at cycle 0; the strobe ends at the first cycle at or after S+T
    // where mem_wait is low, then H hold cycles and one done cycle follow.
    task automatic model_txn(input int d);
        int s, t, h, se, dn;
        logic strobe;
        s  = s_of[d];
        t  = t_of[d];
        h  = h_of[d];
        se = s + t;
        while (se < NC - 1 && wait_pat[se]) se++;
        dn = se + h + 1;
        exp_se[d] = se;
        exp_dn[d] = dn;
        for (int c = 0; c < NC; c++) begin
            strobe = (c >= s + 1) && (c <= se);
            exp_flags[d][c] = {strobe && !req_write, strobe && req_write, c == dn,
                               c >= 1 && c <= dn, !(c >= 1 && c <= dn),
                               strobe && !req_write, strobe && req_write};
            exp_addr[d][c]  = (c >= 1) ? addr_pat[0] : model_addr[d];
            exp_wdata[d][c] = (c >= 1) ? wr_data : model_wdata[d];
            exp_rdd[d][c]   = (c > se && !req_write) ? rdata_pat[se] : model_rdd[d];
        end
        model_addr[d]  = addr_pat[0];
        model_wdata[d] = wr_data;
        if (!req_write) model_rdd[d] = rdata_pat[se];
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            model_addr[d]  = '0;
            model_wdata[d] = '0;
            model_rdd[d]   = '0;
        end
    endtask

    // Entered just after a rising edge; each iteration is one cycle.
    task automatic run(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            rst_n     = rstn_pat[c];
            req_valid = valid_pat[c];
            mem_wait  = wait_pat[c];
            addr_bus  = addr_pat[c];
            mem_rdata = rdata_pat[c];
            @(negedge clk);
            obs_flags[0][c] = {bus_a.mem_rd, bus_a.mem_wr, bus_a.done, bus_a.busy,
                               bus_a.req_ready, bus_a.led_rd, bus_a.led_wr};
            obs_flags[1][c] = {bus_b.mem_rd, bus_b.mem_wr, bus_b.done, bus_b.busy,
                               bus_b.req_ready, bus_b.led_rd, bus_b.led_wr};
            obs_addr[0][c]  = bus_a.mem_addr;
            obs_addr[1][c]  = bus_b.mem_addr;
            obs_wdata[0][c] = bus_a.mem_wdata;
            obs_wdata[1][c] = bus_b.mem_wdata;
            obs_rdd[0][c]   = bus_a.rd_data;
            obs_rdd[1][c]   = bus_b.rd_data;
            @(posedge clk);
            #1;
        end
        rst_n     = 1'b1;
        req_valid = 1'b0;
        mem_wait  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b1;
        mem_wait  = 1'b0;
        addr_bus  = 16'hBEEF;
        wr_data   = 8'h77;
        mem_rdata = 8'h55;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus_a.mem_rd, bus_a.mem_wr, bus_a.done, bus_a.busy, bus_a.req_ready,
             bus_a.led_rd, bus_a.led_wr} !== 7'b0000100) begin
            errors++;
            $display("FAIL reset dutA flags got %b exp 0000100", {bus_a.mem_rd, bus_a.mem_wr,
                     bus_a.done, bus_a.busy, bus_a.req_ready, bus_a.led_rd, bus_a.led_wr});
        end
        checks++;
        if ({bus_b.mem_rd, bus_b.mem_wr, bus_b.done, bus_b.busy, bus_b.req_ready,
             bus_b.led_rd, bus_b.led_wr} !== 7'b0000100) begin
            errors++;
            $display("FAIL reset dutB flags got %b exp 0000100", {bus_b.mem_rd, bus_b.mem_wr,
                     bus_b.done, bus_b.busy, bus_b.req_ready, bus_b.led_rd, bus_b.led_wr});
        end
        checks++;
        if ({bus_a.mem_addr, bus_a.mem_wdata, bus_a.rd_data} !== 32'h0) begin
            errors++;
            $display("FAIL reset dutA addr/wdata/rd_data got %h exp 00000000",
                     {bus_a.mem_addr, bus_a.mem_wdata, bus_a.rd_data});
        end
        checks++;
        if ({bus_b.mem_addr, bus_b.mem_wdata, bus_b.rd_data} !== 32'h0) begin
            errors++;
            $display("FAIL reset dutB addr/wdata/rd_data got %h exp 00000000",
                     {bus_b.mem_addr, bus_b.mem_wdata, bus_b.rd_data});
        end
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        req_valid = 1'b0;
        model_reset();
    endtask

    task automatic test_read_write();
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                stim_default(16'h8034);
                for (int c = 0; c < NC; c++) rdata_pat[c] = 8'hA5;
                req_write = 1'b0;
                wr_data   = 8'h19;
            end else begin
                stim_default(16'h00FF);
                req_write = 1'b1;
                wr_data   = 8'h3C;
            end
            model_txn(0);
            model_txn(1);
            run(10);
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < 10; c++) begin
                    checks++;
                    if (obs_flags[d][c] !== exp_flags[d][c]) begin
                        errors++;
                        $display("FAIL rw%0d dut%0d cyc%0d flags got %b exp %b", k, d, c,
                                 obs_flags[d][c], exp_flags[d][c]);
                    end
                    checks++;
                    if (obs_addr[d][c] !== exp_addr[d][c] || obs_wdata[d][c] !== exp_wdata[d][c]) begin
                        errors++;
                        $display("FAIL rw%0d dut%0d cyc%0d addr/wdata got %h/%h exp %h/%h", k, d, c,
                                 obs_addr[d][c], obs_wdata[d][c], exp_addr[d][c], exp_wdata[d][c]);
                    end
                    checks++;
                    if (obs_rdd[d][c] !== exp_rdd[d][c]) begin
                        errors++;
                        $display("FAIL rw%0d dut%0d cyc%0d rd_data got %h exp %h", k, d, c,
                                 obs_rdd[d][c], exp_rdd[d][c]);
                    end
                end
            end
        end
    endtask

    task automatic test_wait_states();
        stim_default(16'h4A21);
        for (int c = 5; c <= 7; c++) wait_pat[c] = 1'b1;
        req_write = 1'b0;
        wr_data   = 8'h00;
        model_txn(0);
        model_txn(1);
        run(13);
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 13; c++) begin
                checks++;
                if (obs_flags[d][c] !== exp_flags[d][c]) begin
                    errors++;
                    $display("FAIL wait dut%0d cyc%0d flags got %b exp %b", d, c,
                             obs_flags[d][c], exp_flags[d][c]);
                end
                checks++;
                if (obs_rdd[d][c] !== exp_rdd[d][c]) begin
                    errors++;
                    $display("FAIL wait dut%0d cyc%0d rd_data got %h exp %h", d, c,
                             obs_rdd[d][c], exp_rdd[d][c]);
                end
            end
        end
    endtask

    // First two are back-to-back reads at 0000 and FFFF; the rest are random with wait noise.
    task automatic test_random_txns();
        int ncyc;
        for (int i = 0; i < 10; i++) begin
            stim_default((i == 0) ? 16'h0000 : (i == 1) ? 16'hFFFF : 16'($urandom));
            req_write = (i < 2) ? 1'b0 : 1'($urandom);
            wr_data   = 8'($urandom);
            if (i >= 2) begin
                for (int c = 0; c < 20; c++) wait_pat[c] = ($urandom_range(0, 3) == 0);
            end
            model_txn(0);
            model_txn(1);
            ncyc = ((exp_dn[0] > exp_dn[1]) ? exp_dn[0] : exp_dn[1]) + 2;
            run(ncyc);
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < ncyc; c++) begin
                    checks++;
                    if (obs_flags[d][c] !== exp_flags[d][c]) begin
                        errors++;
                        $display("FAIL rand%0d dut%0d cyc%0d flags got %b exp %b", i, d, c,
                                 obs_flags[d][c], exp_flags[d][c]);
                    end
                    checks++;
                    if (obs_addr[d][c] !== exp_addr[d][c] || obs_wdata[d][c] !== exp_wdata[d][c]) begin
                        errors++;
                        $display("FAIL rand%0d dut%0d cyc%0d addr/wdata got %h/%h exp %h/%h", i, d,
                                 c, obs_addr[d][c], obs_wdata[d][c], exp_addr[d][c], exp_wdata[d][c]);
                    end
                    checks++;
                    if (obs_rdd[d][c] !== exp_rdd[d][c]) begin
                        errors++;
                        $display("FAIL rand%0d dut%0d cyc%0d rd_data got %h exp %h", i, d, c,
                                 obs_rdd[d][c], exp_rdd[d][c]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid_strobe();
        stim_default(16'h5A5A);
        for (int c = 0; c < NC; c++) rdata_pat[c] = 8'h80 | 8'($urandom);
        rstn_pat[4] = 1'b0;
        req_write   = 1'b0;
        wr_data     = 8'hC3;
        model_txn(0);
        model_txn(1);
        run(10);
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 10; c++) begin
                checks++;
                if (obs_flags[d][c] !== ((c <= 4) ? exp_flags[d][c] : 7'b0000100)) begin
                    errors++;
                    $display("FAIL rstmid dut%0d cyc%0d flags got %b exp %b", d, c, obs_flags[d][c],
                             (c <= 4) ? exp_flags[d][c] : 7'b0000100);
                end
                checks++;
                if ({obs_addr[d][c], obs_wdata[d][c], obs_rdd[d][c]} !==
                    ((c <= 4) ? {exp_addr[d][c], exp_wdata[d][c], exp_rdd[d][c]} : 32'h0)) begin
                    errors++;
                    $display("FAIL rstmid dut%0d cyc%0d addr/wdata/rd_data got %h exp %h", d, c,
                             {obs_addr[d][c], obs_wdata[d][c], obs_rdd[d][c]},
                             (c <= 4) ? {exp_addr[d][c], exp_wdata[d][c], exp_rdd[d][c]} : 32'h0);
                end
            end
        end
        model_reset();
    endtask

    // req_valid held high and addr_bus changed mid-cycle; the second accept happens in the
    // first idle cycle and only then picks up the new address.
    task automatic test_back_to_back();
        logic [15:0] a0;
        logic [15:0] want_addr;
        int          dn;
        a0 = 16'($urandom) | 16'h0100;
        stim_default(a0);
        for (int c = 0; c < NC; c++) begin
            valid_pat[c] = 1'b1;
            if (c >= 3) addr_pat[c] = 16'h1234;
        end
        rstn_pat[11] = 1'b0;
        req_write    = 1'b0;
        wr_data      = 8'h6E;
        model_txn(0);
        model_txn(1);
        run(12);
        for (int d = 0; d < 2; d++) begin
            dn = exp_dn[d];
            for (int c = 0; c <= dn + 2; c++) begin
                checks++;
                if (obs_flags[d][c][2] !== (c == 0 || c == dn + 1)) begin
                    errors++;
                    $display("FAIL b2b dut%0d cyc%0d req_ready got %b exp %b", d, c,
                             obs_flags[d][c][2], (c == 0 || c == dn + 1));
                end
                want_addr = (c == dn + 2) ? 16'h1234 : exp_addr[d][c];
                checks++;
                if (obs_addr[d][c] !== want_addr) begin
                    errors++;
                    $display("FAIL b2b dut%0d cyc%0d mem_addr got %h exp %h", d, c,
                             obs_addr[d][c], want_addr);
                end
            end
        end
        model_reset();
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        mem_wait  = 1'b0;
        addr_bus  = '0;
        wr_data   = '0;
        mem_rdata = '0;
        model_reset();
        test_reset();
        test_read_write();
        test_wait_states();
        test_random_txns();
        test_reset_mid_strobe();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
